// File: rtl/write_back_pkg.sv
// rtl/write_back_pkg.sv - shared types, opcodes and decode helpers for the write-back scoreboard
package write_back_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    // Width of the rd field carried through the tracking FIFO (covers 32 registers).
    localparam int WB_REG_AW = 5;

    typedef enum logic [1:0] {
        WRITE_BACK_SEL_ALU = 2'd0,
        WRITE_BACK_SEL_MEM = 2'd1,
        WRITE_BACK_SEL_PC  = 2'd2
    } write_back_select_t;

    typedef struct packed {
        logic [WB_REG_AW-1:0] rd;
        write_back_select_t   sel;
        logic                 we;
    } wb_track_entry_t;

    function automatic write_back_select_t wb_decode_sel(input logic [6:0] opcode);
        write_back_select_t sel;
        case (opcode)
            OPCODE_LOAD:             sel = WRITE_BACK_SEL_MEM;
            OPCODE_JAL, OPCODE_JALR: sel = WRITE_BACK_SEL_PC;
            default:                 sel = WRITE_BACK_SEL_ALU;
        endcase
        return sel;
    endfunction

    function automatic logic wb_opcode_writes(input logic [6:0] opcode);
        return (opcode != OPCODE_STORE) && (opcode != OPCODE_BRANCH);
    endfunction

endpackage

// File: rtl/write_back_scoreboard_if.sv
// rtl/write_back_scoreboard_if.sv - decode, completion and register-file port bundle
// Forward outputs exist only when WRITE_BACK_BYPASS_EN is defined.
interface write_back_scoreboard_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int DEPTH    = 4
);
    import write_back_pkg::*;

    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              dec_valid;
    logic              dec_ready;
    logic [6:0]        dec_opcode;
    logic [REG_AW-1:0] dec_rd;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;

    logic              cmp_valid;
    logic [XLEN-1:0]   cmp_alu;
    logic [XLEN-1:0]   cmp_mem;
    logic [XLEN-1:0]   cmp_pc4;

    logic              rf_we;
    logic [REG_AW-1:0] rf_addr;
    logic [XLEN-1:0]   rf_wdata;
    write_back_select_t rf_sel;

    logic [CW-1:0]     inflight;
    logic              err_underflow;
`ifdef WRITE_BACK_BYPASS_EN
    logic              fwd_rs1;
    logic              fwd_rs2;
`endif

    modport master (
        output dec_valid, dec_opcode, dec_rd, dec_rs1, dec_rs2,
        output cmp_valid, cmp_alu, cmp_mem, cmp_pc4,
`ifdef WRITE_BACK_BYPASS_EN
        input  fwd_rs1, fwd_rs2,
`endif
        input  dec_ready, rf_we, rf_addr, rf_wdata, rf_sel, inflight, err_underflow
    );

    modport slave (
        input  dec_valid, dec_opcode, dec_rd, dec_rs1, dec_rs2,
        input  cmp_valid, cmp_alu, cmp_mem, cmp_pc4,
`ifdef WRITE_BACK_BYPASS_EN
        output fwd_rs1, fwd_rs2,
`endif
        output dec_ready, rf_we, rf_addr, rf_wdata, rf_sel, inflight, err_underflow
    );

endinterface

// File: rtl/write_back_track_fifo.sv
// rtl/write_back_track_fifo.sv - synchronous FIFO with wrap-bit pointers, full/empty/count
module write_back_track_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bit means the writer lapped the reader.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/write_back_scoreboard.sv
// rtl/write_back_scoreboard.sv - in-order write-back tracker with busy scoreboard and registered RF port
// Optional: WRITE_BACK_BYPASS_EN lets decode read/overwrite the register being committed this cycle.
module write_back_scoreboard
    import write_back_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int DEPTH    = 4
) (
    input  logic clk,
    input  logic reset,
    write_back_scoreboard_if.slave bus
);

    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int EW     = $bits(wb_track_entry_t);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    logic               dec_we;
    write_back_select_t dec_sel;
    logic               hz;
    logic               dec_ready;
    logic               accept;
    logic               pop;

    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [EW-1:0]      fifo_head;
    wb_track_entry_t    push_entry;
    wb_track_entry_t    head;
    logic [XLEN-1:0]    head_wdata;

    logic               rf_we_q;
    logic [REG_AW-1:0]  rf_addr_q;
    logic [XLEN-1:0]    rf_wdata_q;
    write_back_select_t rf_sel_q;
    logic               err_q;

    assign dec_sel = wb_decode_sel(bus.dec_opcode);
    assign dec_we  = wb_opcode_writes(bus.dec_opcode) && (bus.dec_rd != '0);

`ifdef WRITE_BACK_BYPASS_EN
    logic byp_rs1;
    logic byp_rs2;
    logic byp_rd;

    // The register committing this cycle holds its final value on rf_wdata.
    assign byp_rs1 = rf_we_q && (rf_addr_q == bus.dec_rs1);
    assign byp_rs2 = rf_we_q && (rf_addr_q == bus.dec_rs2);
    assign byp_rd  = rf_we_q && (rf_addr_q == bus.dec_rd);

    assign hz = (busy[bus.dec_rs1] && !byp_rs1)
             || (busy[bus.dec_rs2] && !byp_rs2)
             || (dec_we && busy[bus.dec_rd] && !byp_rd);

    assign bus.fwd_rs1 = byp_rs1;
    assign bus.fwd_rs2 = byp_rs2;
`else
    assign hz = busy[bus.dec_rs1] || busy[bus.dec_rs2] || (dec_we && busy[bus.dec_rd]);
`endif

    assign dec_ready = !reset && !fifo_full && !hz;
    assign accept    = bus.dec_valid && dec_ready;
    assign pop       = bus.cmp_valid && !fifo_empty;

    assign push_entry = '{rd: WB_REG_AW'(bus.dec_rd), sel: dec_sel, we: dec_we};
    assign head       = wb_track_entry_t'(fifo_head);

    write_back_track_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_track_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        head_wdata = bus.cmp_alu;
        case (head.sel)
            WRITE_BACK_SEL_MEM: head_wdata = bus.cmp_mem;
            WRITE_BACK_SEL_PC:  head_wdata = bus.cmp_pc4;
            default:            head_wdata = bus.cmp_alu;
        endcase
    end

    // Clear on commit, then set on accept so a same-cycle re-claim keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (rf_we_q) begin
            busy_nxt[rf_addr_q] = 1'b0;
        end
        if (accept && dec_we) begin
            busy_nxt[bus.dec_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            rf_sel_q   <= WRITE_BACK_SEL_ALU;
            err_q      <= 1'b0;
        end else begin
            rf_we_q <= pop && head.we;
            if (pop) begin
                rf_addr_q  <= REG_AW'(head.rd);
                rf_sel_q   <= head.sel;
                rf_wdata_q <= head_wdata;
            end
            if (bus.cmp_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.dec_ready     = dec_ready;
    assign bus.rf_we         = rf_we_q;
    assign bus.rf_addr       = rf_addr_q;
    assign bus.rf_wdata      = rf_wdata_q;
    assign bus.rf_sel        = rf_sel_q;
    assign bus.inflight      = fifo_count;
    assign bus.err_underflow = err_q;

endmodule

// File: doc/write_back_scoreboard.md
Name: write_back_scoreboard

Overview:
- Second-generation write-back controller. It replaces per-instruction combinational write-back decode with a tracked, in-order write-back pipeline.
- Decodes write-enable and write-back source per issued instruction and records it in an in-order tracking FIFO.
- Keeps a per-register busy scoreboard that stalls decode on RAW/WAW hazards.
- Retires completions into a registered register-file write port. Sits between decode/issue and the register file.

Parameters:
XLEN, 32, data width of register file writes
NUM_REGS, 32, architectural register count; REG_AW = $clog2(NUM_REGS)
DEPTH, 4, tracking FIFO entries (power of two, >= 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
dec_valid  in  1  decode presents an instruction
dec_ready  out  1  instruction accepted when dec_valid && dec_ready
dec_opcode  in  7  instruction opcode
dec_rd  in  REG_AW  destination register
dec_rs1  in  REG_AW  source register 1
dec_rs2  in  REG_AW  source register 2
cmp_valid  in  1  oldest in-flight instruction completes this cycle
cmp_alu  in  XLEN  ALU result
cmp_mem  in  XLEN  load data
cmp_pc4  in  XLEN  PC+4
rf_we  out  1  register file write enable (registered)
rf_addr  out  REG_AW  register file write address (registered)
rf_wdata  out  XLEN  register file write data (registered)
rf_sel  out  write_back_select_t  selected source of the current write, for trace
inflight  out  $clog2(DEPTH)+1  FIFO occupancy
err_underflow  out  1  sticky: cmp_valid seen with empty FIFO

Behaviour:
- Reset (synchronous, active-high): FIFO empty, all busy bits 0, rf_we=0, rf_addr=0, rf_wdata=0, rf_sel=WRITE_BACK_SEL_ALU, err_underflow=0, inflight=0, dec_ready=0. Reset mid-operation discards all in-flight entries with no rf write.
- Decode classification (combinational on dec_*):
  - we = (opcode not OPCODE_STORE and not OPCODE_BRANCH) and rd != 0.
  - sel: OPCODE_LOAD gives MEM; OPCODE_JAL/OPCODE_JALR give PC; everything else gives ALU.
- dec_ready = !reset && !full && !hz.
  - hz = busy[rs1] || busy[rs2] || (we && busy[rd]).
  - busy[0] is always 0.
  - A full FIFO blocks the push even if a pop occurs in the same cycle.
- Accept: push {rd, sel, we} at the tail. Every instruction is pushed, including non-writing ones, so that completion order matches. If we=1, set busy[rd] at the same edge.
- Completion: cmp_valid with a non-empty FIFO pops the head. On the next edge:
  - rf_we = head.we
  - rf_addr = head.rd
  - rf_sel = head.sel
  - rf_wdata = mux(head.sel: ALU→cmp_alu, MEM→cmp_mem, PC→cmp_pc4), sampled in the cmp_valid cycle.
  - Latency is 1 cycle from cmp_valid to rf_we.
- If cmp_valid arrives while no completion is issuing, rf_we=0 the next cycle.
- busy[rd] clears at the edge ending the cycle in which rf_we=1 (the cycle the register file commits). Decode sees the register free one cycle after rf_we.
- Simultaneous set and clear of the same register: set wins. This is only reachable with bypass enabled.
- Empty FIFO with cmp_valid: ignored, err_underflow=1 until reset.
- Simultaneous push and pop is legal when not full; inflight is unchanged.
- FIFO pointers are REG $clog2(DEPTH)+1 bits wide, using the wrap bit for the full/empty distinction. Wrap-around is natural modulo DEPTH.

Optional Feature:
WRITE_BACK_BYPASS_EN
- Defined: hz ignores busy[rs1]/busy[rs2] when rs == rf_addr && rf_we. Two extra outputs are added:
  - fwd_rs1 (1): forward rf_wdata for rs1.
  - fwd_rs2 (1): forward rf_wdata for rs2.
  - Likewise, a WAW on rf_addr with rf_we=1 does not stall.
- Undefined: no forward ports; stall until busy clears.

Decomposition:
- write_back_pkg (shared package):
  - write_back_select_t
  - wb_track_entry_t {rd, sel, we}
  - OPCODE_* constants, taken from instructions_pkg
- Sub-module: write_back_track_fifo, a parametrised synchronous FIFO with full/empty/count. The scoreboard and decode logic stay in the top.

Test Plan:
- Issue ADDI x5, then cmp_valid with cmp_alu=0x1234. Expect rf_we=1, rf_addr=5, rf_wdata=0x1234 one cycle later; busy[5] clear the following cycle.
- Issue LW x7, then ADD x8,x7,x1. Expect dec_ready=0 until one cycle after the rf_we for x7; cmp_mem=0xDEADBEEF is written, not cmp_alu.
- Issue SW, BEQ, JAL x1 with in-order cmp_valid pulses. Expect rf_we=0, then 0, then 1 with addr=1 and data=cmp_pc4.
- Issue 4 non-hazard instructions with no completions. Expect inflight=4 and dec_ready=0. Pop one: dec_ready=1 the next cycle and pointers wrap correctly over 3 fill/drain rounds.
- Pulse cmp_valid on an empty FIFO. Expect err_underflow=1 and no rf_we. Assert reset with 3 entries in flight: all busy cleared, inflight=0, no rf_we.
- With WRITE_BACK_BYPASS_EN, decode rs1=x5 while rf_we=1 and rf_addr=5. Expect dec_ready=1 and fwd_rs1=1. Without the macro, expect dec_ready=0.
